col_parity_stage: RTL and testbench

First round step of the 24-round permutation datapath: the column-parity (theta) stage. On `colParity_en` from the round controller it reads the 25-lane state from the shared state memory, forms the five column parities, and writes every lane back XORed with its column correction term. It then pulses `done1` so the controller advances to the Rotate step.

---
 rtl/perm_pkg.sv | 36 +++
 rtl/lane_xy_counter.sv | 73 +++++++
 rtl/col_parity_stage.sv | 145 ++++++++++++++
 tb/tb_col_parity_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : perm_pkg
// Description : Shared constants, state encoding and helpers for the
//               24-round permutation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package perm_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int NUM_COLS  = 5;
    localparam int NUM_ROWS  = 5;

    // Lane counter widths: count reaches 25 in the update pass, y reaches 5.
    localparam int CNT_W = 5;
    localparam int XY_W  = 3;

    typedef logic [LANE_W-1:0] lane_t;

    // Column-parity stage sequencer states.
    typedef enum logic [2:0] {
        CP_IDLE = 3'd0,
        CP_RD   = 3'd1,
        CP_CALC = 3'd2,
        CP_UPD  = 3'd3,
        CP_DONE = 3'd4
    } cp_state_e;

    // Rotate a lane left by one; the top bit wraps into bit 0.
    function automatic lane_t rotl1(input lane_t v);
        return {v[LANE_W-2:0], v[LANE_W-1]};
    endfunction

endpackage : perm_pkg
`default_nettype wire

// File: rtl/lane_xy_counter.sv
`default_nettype none
// ============================================================================
// Module      : lane_xy_counter
// Description : Lane position counter. Walks cnt = 5*y + x with separate
//               x and y counters so no divide/modulo is needed. Terminal
//               count is 24, or 25 when wrap_ext_i is set.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_xy_counter
    import perm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             wrap_ext_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [XY_W-1:0]  x_o,
    output logic [XY_W-1:0]  y_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XY_W-1:0]  x_q, x_d;
    logic [XY_W-1:0]  y_q, y_d;

    assign cnt_o  = cnt_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = wrap_ext_i ? (cnt_q == CNT_W'(NUM_LANES))
                               : (cnt_q == CNT_W'(NUM_LANES - 1));

    // Next position: clear wins, terminal count wraps to zero, else step x then y.
    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        y_d   = y_q;
        if (clr_i) begin
            cnt_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (en_i) begin
            if (last_o) begin
                cnt_d = '0;
                x_d   = '0;
                y_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (x_q == XY_W'(NUM_COLS - 1)) begin
                    x_d = '0;
                    y_d = y_q + XY_W'(1);
                end else begin
                    x_d = x_q + XY_W'(1);
                end
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

endmodule : lane_xy_counter
`default_nettype wire

// File: rtl/col_parity_stage.sv
`default_nettype none
// ============================================================================
// Module      : col_parity_stage
// Description : Column-parity (theta) round step. Reads all 25 lanes to
//               build the column parities C[x], then rewrites every lane
//               as A ^ D[x] with D[x] = C[x-1] ^ rotl1(C[x+1]), and pulses
//               done1 for the round controller.
// Revision    : 1.0 - initial release
// ============================================================================
module col_parity_stage #(
    parameter int LANE_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              colParity_en,
    output logic              done1,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [LANE_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LANE_W-1:0] mem_wr_data
);

    import perm_pkg::*;

    cp_state_e         state_q, state_d;
    logic              armed_q, armed_d;
    logic [LANE_W-1:0] c_q [NUM_COLS];
    logic [LANE_W-1:0] c_d [NUM_COLS];
    logic [LANE_W-1:0] w_d [NUM_COLS];
    // Column of the lane whose read data arrives this cycle.
    logic [XY_W-1:0]   px_q;

    logic [CNT_W-1:0]  w_cnt;
    logic [XY_W-1:0]   w_x;
    logic [XY_W-1:0]   w_y;
    logic              w_last;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_wrap_ext;
    logic              w_wr_en;

    lane_xy_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_cnt_clr),
        .en_i       (w_cnt_en),
        .wrap_ext_i (w_wrap_ext),
        .cnt_o      (w_cnt),
        .x_o        (w_x),
        .y_o        (w_y),
        .last_o     (w_last)
    );

    // Correction terms are purely combinational from the parity registers.
    for (genvar gx = 0; gx < NUM_COLS; gx++) begin : g_dcol
        assign w_d[gx] = c_q[(gx + NUM_COLS - 1) % NUM_COLS]
                       ^ rotl1(c_q[(gx + 1) % NUM_COLS]);
    end

    // Sequencer: arm on low enable, accumulate parities, then rewrite lanes.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        c_d        = c_q;
        w_cnt_clr  = 1'b0;
        w_cnt_en   = 1'b0;
        w_wrap_ext = 1'b0;
        case (state_q)
            CP_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!colParity_en) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    for (int i = 0; i < NUM_COLS; i++) c_d[i] = '0;
                    state_d = CP_RD;
                end
            end
            CP_RD: begin
                w_cnt_en = 1'b1;
                // First read cycle has no data yet.
                if (w_cnt != '0) c_d[px_q] = c_q[px_q] ^ mem_rd_data;
                if (w_last) state_d = CP_CALC;
            end
            CP_CALC: begin
                // Lane 24 arrives now; it always sits in the last column.
                c_d[NUM_COLS-1] = c_q[NUM_COLS-1] ^ mem_rd_data;
                state_d         = CP_UPD;
            end
            CP_UPD: begin
                w_cnt_en   = 1'b1;
                w_wrap_ext = 1'b1;
                if (w_last) state_d = CP_DONE;
            end
            CP_DONE: begin
                w_cnt_clr = 1'b1;
                state_d   = CP_IDLE;
            end
            default: begin
                w_cnt_clr = 1'b1;
                state_d   = CP_IDLE;
            end
        endcase
    end

    // State, arm flag, parity registers and delayed column index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CP_IDLE;
            armed_q <= 1'b1;
            px_q    <= '0;
            for (int i = 0; i < NUM_COLS; i++) c_q[i] <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            px_q    <= w_x;
            for (int i = 0; i < NUM_COLS; i++) c_q[i] <= c_d[i];
        end
    end

    // Write-back of lane cnt-1 overlaps the read of lane cnt.
    assign w_wr_en = (state_q == CP_UPD) && (w_cnt != '0);

    // Memory-side outputs; all idle values are zero.
    always_comb begin
        done1       = (state_q == CP_DONE);
        mem_wr_en   = w_wr_en;
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        // y reaches NUM_ROWS only on the final write-only update cycle.
        if ((state_q == CP_RD) ||
            ((state_q == CP_UPD) && (w_y != XY_W'(NUM_ROWS)))) begin
            mem_rd_addr = ADDR_W'(w_cnt);
        end
        if (w_wr_en) begin
            mem_wr_addr = ADDR_W'(w_cnt - CNT_W'(1));
            mem_wr_data = mem_rd_data ^ w_d[px_q];
        end
    end

endmodule : col_parity_stage
`default_nettype wire

// File: tb/tb_col_parity_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_col_parity_stage
// Description : Self-checking bench for col_parity_stage with a lane memory
//               model and a software theta reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_col_parity_stage;

    localparam int LW = 64;
    localparam int NL = 25;

    typedef logic [LW-1:0] tb_lane_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        colParity_en;
    logic        done1;
    logic [4:0]  mem_rd_addr;
    tb_lane_t    mem_rd_data;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    tb_lane_t    mem_wr_data;

    tb_lane_t    mem      [NL];
    tb_lane_t    load_img [NL];
    tb_lane_t    exp_img  [NL];
    logic        load_en;
    logic        mon_on;
    int          exp_addr;
    int          wr_count;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    col_parity_stage #(.LANE_W(64), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .colParity_en (colParity_en),
        .done1        (done1),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Software theta: column parities, neighbour correction, lane XOR.
    function automatic void theta_ref(input tb_lane_t a [NL], output tb_lane_t r [NL]);
        tb_lane_t c [5];
        tb_lane_t d [5];
        for (int x = 0; x < 5; x++) c[x] = '0;
        for (int i = 0; i < NL; i++) c[i % 5] ^= a[i];
        for (int x = 0; x < 5; x++)
            d[x] = c[(x + 4) % 5] ^ ((c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> 63));
        for (int i = 0; i < NL; i++) r[i] = a[i] ^ d[i % 5];
    endfunction

    // Lane memory: synchronous 1-cycle read, independent write port, bulk load.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < NL; i++) mem[i] <= load_img[i];
        end else if (mem_wr_en && mem_wr_addr < 5'd25) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
        if (mem_rd_addr < 5'd25) mem_rd_data <= mem[mem_rd_addr];
        else                     mem_rd_data <= 'x;
    end

    // Write scoreboard: in-order addresses and reference data.
    always @(negedge clk) begin
        if (mon_on && mem_wr_en) begin
            chk("wr_addr", 64'(mem_wr_addr), 64'(exp_addr));
            chk("wr_data_x", 64'($isunknown(mem_wr_data)), 64'(0));
            if (mem_wr_addr < 5'd25) chk("wr_data", mem_wr_data, exp_img[mem_wr_addr]);
            exp_addr++;
            wr_count++;
        end
    end

    task automatic randomize_img();
        for (int i = 0; i < NL; i++) load_img[i] = {$urandom, $urandom};
    endtask

    task automatic clear_img();
        for (int i = 0; i < NL; i++) load_img[i] = '0;
    endtask

    // Load load_img, drop enable one cycle, start, and time done1.
    // abort_at != 0 asserts reset in that cycle instead of finishing.
    task automatic run_theta(input bit hold_en, input int abort_at);
        int n;
        bit seen;
        bit aborted;
        @(negedge clk);
        colParity_en = 1'b0;
        load_en      = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        theta_ref(load_img, exp_img);
        exp_addr     = 0;
        wr_count     = 0;
        mon_on       = 1'b1;
        colParity_en = 1'b1;
        n       = 0;
        seen    = 1'b0;
        aborted = 1'b0;
        while (n < 120 && !seen && !aborted) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == abort_at) begin
                chk("abort_pre_wr_en", 64'(mem_wr_en), 64'(1));
                chk("abort_pre_wr_addr", 64'(mem_wr_addr), 64'(n - 28));
                #1 rst = 1'b0;
                #1;
                chk("abort_wr_en", 64'(mem_wr_en), 64'(0));
                chk("abort_done1", 64'(done1), 64'(0));
                chk("abort_rd_addr", 64'(mem_rd_addr), 64'(0));
                mon_on       = 1'b0;
                colParity_en = 1'b0;
                @(negedge clk);
                rst     = 1'b1;
                aborted = 1'b1;
            end else if (done1) begin
                seen = 1'b1;
            end
        end
        if (!aborted) begin
            if (!hold_en) colParity_en = 1'b0;
            mon_on = 1'b0;
            chk("done_cycle", 64'(seen ? n : 0), 64'(53));
            chk("wr_count", 64'(wr_count), 64'(25));
            for (int i = 0; i < NL; i++) chk("mem_lane", mem[i], exp_img[i]);
        end
    endtask

    initial begin
        tb_lane_t top_bit;
        bit       retrig;
        top_bit      = 64'h8000_0000_0000_0000;
        rst          = 1'b0;
        colParity_en = 1'b0;
        load_en      = 1'b0;
        mon_on       = 1'b0;
        exp_addr     = 0;
        wr_count     = 0;
        clear_img();

        repeat (3) @(negedge clk);
        chk("rst_done1", 64'(done1), 64'(0));
        chk("rst_wr_en", 64'(mem_wr_en), 64'(0));
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'(0));
        chk("rst_wr_data", mem_wr_data, 64'(0));
        rst = 1'b1;

        // All-zero state stays zero.
        clear_img();
        run_theta(1'b0, 0);

        // Single bit in lane (0,0).
        clear_img();
        load_img[0] = 64'h1;
        run_theta(1'b0, 0);
        for (int y = 0; y < 5; y++) begin
            chk("one_x1", mem[5*y+1], 64'h1);
            chk("one_x4", mem[5*y+4], 64'h2);
        end
        chk("one_lane00", mem[0], 64'h1);
        chk("one_lane20", mem[2], 64'h0);

        // Top bit in lane (2,0) exercises the rotate wrap.
        clear_img();
        load_img[2] = top_bit;
        run_theta(1'b0, 0);
        for (int y = 0; y < 5; y++) begin
            chk("wrap_x3", mem[5*y+3], top_bit);
            chk("wrap_x1", mem[5*y+1], 64'h1);
        end
        chk("wrap_lane20", mem[2], top_bit);

        // Enable held high after done1 must not retrigger.
        randomize_img();
        run_theta(1'b1, 0);
        retrig = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd_addr != 5'd0 || done1 || mem_wr_en) retrig = 1'b1;
        end
        chk("no_retrigger", 64'(retrig), 64'(0));
        randomize_img();
        run_theta(1'b0, 0);

        // Reset in UPD cnt=10 (cycle 37), then a clean run.
        randomize_img();
        run_theta(1'b0, 37);
        randomize_img();
        run_theta(1'b0, 0);

        // Random states.
        for (int t = 0; t < 200; t++) begin
            randomize_img();
            run_theta(1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_col_parity_stage
`default_nettype wire
